nibble_serial_adder: RTL

- Multi-cycle WIDTH-bit adder that feeds the existing 4-bit ripple-carry adder one nibble per cycle, LSB nibble first, and registers the carry between cycles.
- Sits in the datapath beside adder_4bit, trading latency for area on wide operands.
- Valid/ready handshakes on both the input side and the result side.

---
 rtl/nibble_serial_adder_pkg.sv | 22 ++
 rtl/nibble_serial_adder_adder_4bit.sv | 14 +
 rtl/nibble_serial_adder.sv | 105 ++++++++++
 3 files changed

// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: FSM encoding, nibble width
// and small helpers used by the top level.
package nibble_serial_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // The unused code 2'd3 behaves exactly like IDLE.
    function automatic logic is_idle(input state_t s);
        return !((s == RUN) || (s == DONE));
    endfunction

    function automatic int idx_width(input int nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_adder_4bit.sv
// Combinational 4-bit adder slice used once per cycle by the serial adder.
module adder_4bit
    import nibble_serial_adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] A,
    input  logic [NIBBLE_W-1:0] B,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout
);

    assign {cout, sum} = {1'b0, A} + {1'b0, B} + {{NIBBLE_W{1'b0}}, cin};

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that pushes one nibble per cycle through a single adder_4bit,
// LSB nibble first, with the carry held in a register between cycles.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = idx_width(NIBBLES);

    state_t             state;
    state_t             next_state;
    logic [IDX_W-1:0]   idx;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic               carry_reg;
    logic [NIBBLE_W-1:0] nib_sum;
    logic               nib_cout;
    logic               last_nibble;

    assign last_nibble = (idx == IDX_W'(NIBBLES - 1));

    adder_4bit u_adder (
        .A    (a_reg[NIBBLE_W*idx +: NIBBLE_W]),
        .B    (b_reg[NIBBLE_W*idx +: NIBBLE_W]),
        .cin  (carry_reg),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: next_state gets a default first so no path through the case can
    // leave it unassigned and infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            RUN:     if (last_nibble) next_state = DONE;
            DONE:    if (out_ready)   next_state = IDLE;
            default: if (in_valid)    next_state = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            carry_reg <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum       <= '0;
            cout      <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    sum[NIBBLE_W*idx +: NIBBLE_W] <= nib_sum;
                    carry_reg                     <= nib_cout;
                    if (last_nibble) begin
                        cout <= nib_cout;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    // Result is held until the consumer takes it.
                end
                default: begin
                    if (in_valid) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        carry_reg <= cin;
                        idx       <= '0;
                        sum       <= '0;
                    end
                end
            endcase
        end
    end

    assign in_ready  = is_idle(state);
    assign out_valid = (state == DONE);
    assign busy      = (state == RUN) || (state == DONE);

endmodule
